// File: rtl/key_event_conditioner.sv
// Key event conditioner: synchronises and debounces active-low pushbuttons and
// turns each accepted level change into a single-cycle event pulse.
module key_event_conditioner #(
    parameter int unsigned NUM_KEYS        = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] KEY_DOWN,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE,
    output logic [NUM_KEYS-1:0] KEY_CLICK,
    output logic [NUM_KEYS-1:0] KEY_HOLD
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_UP           = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_DOWN         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic             r_sync1;
        logic             r_sync2;
        logic             w_p;
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_deb_cnt;
        logic [CNT_W-1:0] w_deb_cnt_nxt;
        logic [CNT_W-1:0] r_hold_cnt;
        logic [CNT_W-1:0] w_hold_cnt_nxt;
        logic             r_hold_fired;
        logic             w_hold_fired_nxt;
        logic             r_down;
        logic             r_press;
        logic             r_release;
        logic             r_click;
        logic             r_hold;
        logic             w_down_nxt;
        logic             w_press_nxt;
        logic             w_release_nxt;
        logic             w_click_nxt;
        logic             w_hold_nxt;

        // Pressed level seen by the FSM (buttons are active-low).
        assign w_p = ~r_sync2;

        // Two-flop synchroniser; resets to the released level.
        always_ff @(posedge CLOCK_50) begin
            if (RESET) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
            end else begin
                r_sync1 <= KEY[g];
                r_sync2 <= r_sync1;
            end
        end

        // State, counters and registered event outputs.
        always_ff @(posedge CLOCK_50) begin
            if (RESET) begin
                r_state      <= ST_UP;
                r_deb_cnt    <= '0;
                r_hold_cnt   <= '0;
                r_hold_fired <= 1'b0;
                r_down       <= 1'b0;
                r_press      <= 1'b0;
                r_release    <= 1'b0;
                r_click      <= 1'b0;
                r_hold       <= 1'b0;
            end else begin
                r_state      <= w_state_nxt;
                r_deb_cnt    <= w_deb_cnt_nxt;
                r_hold_cnt   <= w_hold_cnt_nxt;
                r_hold_fired <= w_hold_fired_nxt;
                r_down       <= w_down_nxt;
                r_press      <= w_press_nxt;
                r_release    <= w_release_nxt;
                r_click      <= w_click_nxt;
                r_hold       <= w_hold_nxt;
            end
        end

        // Debounce FSM, saturating hold counter and event generation.
        always_comb begin
            w_state_nxt      = r_state;
            w_deb_cnt_nxt    = r_deb_cnt;
            w_hold_cnt_nxt   = r_hold_cnt;
            w_hold_fired_nxt = r_hold_fired;
            w_press_nxt      = 1'b0;
            w_release_nxt    = 1'b0;
            w_click_nxt      = 1'b0;
            w_hold_nxt       = 1'b0;

            // Hold timing keeps running through a release glitch.
            if (r_state == ST_DOWN || r_state == ST_RELEASE_WAIT) begin
                if (r_hold_cnt == HOLD_LAST) begin
                    if (!r_hold_fired) begin
                        w_hold_nxt       = 1'b1;
                        w_hold_fired_nxt = 1'b1;
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end
            end

            case (r_state)
                ST_UP: begin
                    if (w_p) begin
                        w_state_nxt   = ST_PRESS_WAIT;
                        w_deb_cnt_nxt = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_p) begin
                        w_state_nxt = ST_UP;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        w_state_nxt      = ST_DOWN;
                        w_press_nxt      = 1'b1;
                        w_hold_cnt_nxt   = '0;
                        w_hold_fired_nxt = 1'b0;
                    end else begin
                        w_deb_cnt_nxt = r_deb_cnt + CNT_W'(1);
                    end
                end
                ST_DOWN: begin
                    if (!w_p) begin
                        w_state_nxt   = ST_RELEASE_WAIT;
                        w_deb_cnt_nxt = '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (w_p) begin
                        w_state_nxt = ST_DOWN;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        w_state_nxt   = ST_UP;
                        w_release_nxt = 1'b1;
                        // A hold firing on this same edge still counts as held.
                        w_click_nxt   = ~(r_hold_fired | w_hold_nxt);
                    end else begin
                        w_deb_cnt_nxt = r_deb_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_UP;
                end
            endcase

            w_down_nxt = (w_state_nxt == ST_DOWN) || (w_state_nxt == ST_RELEASE_WAIT);
        end

        assign KEY_DOWN[g]    = r_down;
        assign KEY_PRESS[g]   = r_press;
        assign KEY_RELEASE[g] = r_release;
        assign KEY_CLICK[g]   = r_click;
        assign KEY_HOLD[g]    = r_hold;
    end

endmodule
